nes_joypad_port: RTL and testbench
==================================

NES_JOYPAD_PORT -- requirements
Module: nes_joypad_port

Interface
REQ-001 Parameter TURBO_HALF, default 715909, is the number of clk cycles per turbo phase half-period (~15 Hz press rate at 21.477 MHz).
REQ-002 Parameter TURBO_W, default 20, is the turbo counter width; TURBO_HALF SHALL be at most 2^TURBO_W.
REQ-003 clk  input  1  21.477 MHz main clock; the block's only clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 joy1_btns  input  12  port-1 buttons, active-high, clk domain: [0] A, [1] B, [2] SELECT, [3] START, [4] UP, [5] DOWN, [6] LEFT, [7] RIGHT, [8] X (turbo A), [9] Y (turbo B), [11:10] unused.
REQ-006 joy2_btns  input  12  port-2 buttons, same layout as joy1_btns.
REQ-007 turbo_en  input  1  when 1, X and Y act as auto-fire A and B.
REQ-008 joypad_strobe  input  1  $4016 bit 0 from the CPU core; level-sensitive.
REQ-009 joypad_clock  input  2  per-port read clocks from the CPU core; [0] is port 1, [1] is port 2.
REQ-010 joypad1_data  output  1  serial button bit for port 1, active-high pressed.
REQ-011 joypad2_data  output  1  serial button bit for port 2.
REQ-012 turbo_phase  output  1  current auto-fire phase, for debug and LED use.

Function
REQ-013 Each port SHALL hold an 8-bit shift register; its data output SHALL equal bit 0 of that register.
REQ-014 Load value = {btns[7:2], btns[1] | (turbo_en & btns[9] & turbo_phase), btns[0] | (turbo_en & btns[8] & turbo_phase)}.
REQ-015 While joypad_strobe = 1, each shift register SHALL be reloaded with the load value on every clk edge, so data tracks live A with 1-cycle latency.
REQ-016 The block SHALL register joypad_clock once per cycle and detect a falling edge on bit n as previous = 1 and current = 0.
REQ-017 On a falling edge with strobe = 0, the register SHALL shift right with 1 entering bit 7.
REQ-018 After the 8th shift, data SHALL read 1 and remain 1 on all further shifts until the next load.
REQ-019 When strobe = 1 and a falling edge occur in the same cycle, the load SHALL win and no shift SHALL occur.
REQ-020 The two ports SHALL be independent; simultaneous edges on both clock bits SHALL shift both registers in the same cycle.
REQ-021 The turbo counter SHALL count 0 to TURBO_HALF-1 every cycle and wrap to 0.
REQ-022 turbo_phase SHALL toggle in the cycle the counter wraps.
REQ-023 The counter SHALL run regardless of turbo_en.
REQ-024 A change of turbo_en or of the buttons SHALL only affect the next load; it SHALL NOT alter a register mid-shift.
REQ-025 Button inputs SHALL be sampled only at load; no debouncing or synchronisation is performed, since inputs are already in the clk domain.

Reset
REQ-026 On reset assertion, asynchronously: both shift registers = 8'h00, registered joypad_clock = 2'b00, turbo counter = 0, turbo_phase = 0; hence both data outputs = 0.
REQ-027 Reset asserted mid-read SHALL abort the sequence; after release, the first falling edge shifts from 8'h00.
REQ-028 Release is synchronised by the upstream reset logic; no internal synchroniser is required.

Structure
REQ-029 Button bit indices (BTN_A .. BTN_Y) and the TURBO_HALF default SHALL live in the shared configuration package.
REQ-030 One sub-module, joypad_shifter (load value, strobe, clock bit -> data), SHALL be instantiated once per port.
REQ-031 The turbo generator and the load-value mux SHALL be in the top of this block.

Verification
REQ-032 joy1_btns = 12'h009, strobe 1 then 0, 8 falling edges on clock[0] -> joypad1_data sequence 1,0,0,1,0,0,0,0, then 1 on the 9th and 10th edges.
REQ-033 Strobe held 1 with clock[0] toggling, A toggled -> data follows A 1 cycle later and no shift is seen.
REQ-034 TURBO_HALF = 4, turbo_en = 1, X held -> turbo_phase period is 8 cycles; reads taken at alternate phases return A = 1 then A = 0.
REQ-035 Strobe falling in the same cycle as a clock[1] falling edge, joy2_btns = 12'h0FF -> no shift, and the first bit read is 1.
REQ-036 Reset pulsed after 3 shifts on port 1 -> joypad1_data = 0 immediately; the next edge gives 0 and bit 7 becomes 1.
REQ-037 Both clocks falling together with different buttons on each port -> each port outputs its own sequence without cross-talk.

Source files
------------

// File: rtl/nes_joypad_port_pkg.sv
// Shared configuration for the NES joypad port: button bit positions,
// turbo timing defaults and the parallel-load value helper.
package nes_joypad_port_pkg;

    // Button bit indices within the 12-bit button vectors.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_X      = 8;
    localparam int BTN_Y      = 9;

    // ~15 Hz auto-fire at 21.477 MHz: 715909 cycles per half-period.
    localparam int TURBO_HALF_DEFAULT = 715909;
    localparam int TURBO_W_DEFAULT    = 20;

    localparam int SR_W = 8;

    // Parallel-load value: X/Y act as auto-fire A/B while turbo is enabled
    // and the turbo phase is high; the other six buttons pass straight through.
    function automatic logic [SR_W-1:0] load_value(
        input logic [9:0] btns,
        input logic       turbo_en,
        input logic       phase
    );
        logic [SR_W-1:0] v;
        v        = btns[SR_W-1:0];
        v[BTN_A] = btns[BTN_A] | (turbo_en & btns[BTN_X] & phase);
        v[BTN_B] = btns[BTN_B] | (turbo_en & btns[BTN_Y] & phase);
        return v;
    endfunction

endpackage

// File: rtl/nes_joypad_port_shifter.sv
// One controller port: 8-bit parallel-load / serial-out shift register.
// Strobe high reloads every cycle (and beats a coincident clock edge);
// a falling edge of the read clock with strobe low shifts right with 1 in,
// so reads past the 8th bit return 1 like a real 4021.
module joypad_shifter
    import nes_joypad_port_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [SR_W-1:0] load_val,
    input  logic            strobe,
    input  logic            clk_bit,
    output logic            data
);

    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] sr_d;
    logic            clk_bit_q;
    logic            fall;

    assign fall = clk_bit_q & ~clk_bit;

    // Next shift-register value: load has priority over shift.
    always_comb begin
        sr_d = sr_q;
        if (strobe) begin
            sr_d = load_val;
        end else if (fall) begin
            sr_d = {1'b1, sr_q[SR_W-1:1]};
        end
    end

    // Shift register and previous read-clock level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q      <= '0;
            clk_bit_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            clk_bit_q <= clk_bit;
        end
    end

    assign data = sr_q[0];

endmodule

// File: rtl/nes_joypad_port.sv
// NES $4016/$4017 joypad port: two independent serial shifters plus a
// free-running turbo (auto-fire) phase generator shared by both ports.
module nes_joypad_port
    import nes_joypad_port_pkg::*;
#(
    parameter int TURBO_HALF = TURBO_HALF_DEFAULT,
    parameter int TURBO_W    = TURBO_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] joy1_btns,
    input  logic [11:0] joy2_btns,
    input  logic        turbo_en,
    input  logic        joypad_strobe,
    input  logic [1:0]  joypad_clock,
    output logic        joypad1_data,
    output logic        joypad2_data,
    output logic        turbo_phase
);

    logic [TURBO_W-1:0] cnt_q;
    logic [TURBO_W-1:0] cnt_d;
    logic               phase_q;
    logic               phase_d;
    logic               wrap;
    logic [SR_W-1:0]    load1;
    logic [SR_W-1:0]    load2;
    logic               unused_btns;

    assign unused_btns = ^{joy1_btns[11:10], joy2_btns[11:10]};

    assign wrap = (cnt_q == TURBO_W'(TURBO_HALF - 1));

    // Turbo counter runs 0..TURBO_HALF-1 regardless of turbo_en; phase flips on wrap.
    always_comb begin
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        phase_d = phase_q ^ wrap;
    end

    // Turbo counter and phase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign turbo_phase = phase_q;

    assign load1 = load_value(joy1_btns[9:0], turbo_en, phase_q);
    assign load2 = load_value(joy2_btns[9:0], turbo_en, phase_q);

    joypad_shifter u_port1 (
        .clk      (clk),
        .reset    (reset),
        .load_val (load1),
        .strobe   (joypad_strobe),
        .clk_bit  (joypad_clock[0]),
        .data     (joypad1_data)
    );

    joypad_shifter u_port2 (
        .clk      (clk),
        .reset    (reset),
        .load_val (load2),
        .strobe   (joypad_strobe),
        .clk_bit  (joypad_clock[1]),
        .data     (joypad2_data)
    );

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed bench for nes_joypad_port with a per-port expected-bit scoreboard.
module tb_nes_joypad_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] joy1_btns;
    logic [11:0] joy2_btns;
    logic        turbo_en;
    logic        joypad_strobe;
    logic [1:0]  joypad_clock;
    logic        joypad1_data;
    logic        joypad2_data;
    logic        turbo_phase;

    int n_asserts = 0;
    int n_fails   = 0;
    int cyc       = 0;

    logic exp1_q[$];
    logic exp2_q[$];

    nes_joypad_port #(.TURBO_HALF(4), .TURBO_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .joy1_btns     (joy1_btns),
        .joy2_btns     (joy2_btns),
        .turbo_en      (turbo_en),
        .joypad_strobe (joypad_strobe),
        .joypad_clock  (joypad_clock),
        .joypad1_data  (joypad1_data),
        .joypad2_data  (joypad2_data),
        .turbo_phase   (turbo_phase)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) cyc++;
    endtask

    // Phase after cyc clock edges since reset release, half-period 4.
    function automatic logic model_phase();
        return ((cyc >> 2) & 1) != 0;
    endfunction

    function automatic logic [7:0] model_load(input logic [11:0] b, input logic ten, input logic ph);
        return {b[7:2], b[1] | (ten & b[9] & ph), b[0] | (ten & b[8] & ph)};
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_read(input int port, input logic [7:0] lv, input int n);
        for (int k = 0; k < n; k++) begin
            logic b;
            b = (k < 8) ? lv[k] : 1'b1;
            if (port == 1) exp1_q.push_back(b);
            else           exp2_q.push_back(b);
        end
    endtask

    task automatic pop_check(input int port, input string tag);
        logic e;
        if ((port == 1 && exp1_q.size() == 0) || (port == 2 && exp2_q.size() == 0)) begin
            n_asserts++;
            n_fails++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
            return;
        end
        if (port == 1) begin
            e = exp1_q.pop_front();
            check(tag, joypad1_data, e);
        end else begin
            e = exp2_q.pop_front();
            check(tag, joypad2_data, e);
        end
    endtask

    // Check the current bit on each selected port, then give it one falling edge.
    task automatic edges(input logic [1:0] mask, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            if (mask[0]) pop_check(1, tag);
            if (mask[1]) pop_check(2, tag);
            joypad_clock = mask;
            tick();
            joypad_clock = 2'b00;
            tick();
        end
    endtask

    task automatic load();
        joypad_strobe = 1'b1;
        tick();
        joypad_strobe = 1'b0;
        tick();
    endtask

    task automatic turbo_read(input logic want_phase, input int nread, input string tag);
        logic [7:0] lv;
        for (int i = 0; i < 8 && model_phase() != want_phase; i++) tick();
        lv = model_load(joy1_btns, turbo_en, model_phase());
        joypad_strobe = 1'b1;
        tick();
        joypad_strobe = 1'b0;
        push_read(1, lv, nread);
        edges(2'b01, nread, tag);
    endtask

    initial begin
        logic a;
        reset         = 1'b1;
        joy1_btns     = '0;
        joy2_btns     = '0;
        turbo_en      = 1'b0;
        joypad_strobe = 1'b0;
        joypad_clock  = 2'b00;
        #2;
        check("rst_data1", joypad1_data, 1'b0);
        check("rst_data2", joypad2_data, 1'b0);
        check("rst_phase", turbo_phase, 1'b0);

        // Strobe and buttons during reset must not load.
        joypad_strobe = 1'b1;
        joy1_btns     = 12'hFFF;
        @(posedge clk);
        #1;
        check("rst_hold_data1", joypad1_data, 1'b0);
        joypad_strobe = 1'b0;
        joy1_btns     = '0;
        reset         = 1'b0;
        cyc           = 0;

        // Turbo phase: 4 cycles low, 4 high, period 8.
        for (int i = 0; i < 16; i++) begin
            tick();
            check("turbo_phase", turbo_phase, model_phase());
        end

        // Basic read of START+A, two extra reads return 1.
        joy1_btns = 12'h009;
        load();
        push_read(1, 8'h09, 10);
        edges(2'b01, 10, "read_009");

        // Strobe held: data tracks A one cycle later, clock edges ignored.
        joypad_strobe = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = (i % 3 == 0);
            joy1_btns    = {10'b0, ~a, a};
            joypad_clock = (i % 2 == 0) ? 2'b01 : 2'b00;
            tick();
            exp1_q.push_back(a);
            pop_check(1, "strobe_track");
        end
        joypad_strobe = 1'b0;
        joypad_clock  = 2'b00;
        tick();

        // Turbo: X held, loads on alternate phases give A=1 then A=0.
        turbo_en  = 1'b1;
        joy1_btns = 12'h100;
        turbo_read(1'b1, 2, "turbo_a_hi");
        turbo_read(1'b0, 2, "turbo_a_lo");
        turbo_read(1'b1, 2, "turbo_a_hi2");
        joy1_btns = 12'h200;
        turbo_read(1'b1, 3, "turbo_b_hi");
        turbo_en  = 1'b0;
        joy1_btns = 12'h100;
        turbo_read(1'b1, 2, "turbo_off");

        // Strobe still high on the clock[1] falling edge: load wins.
        joy2_btns     = 12'h0FF;
        joypad_strobe = 1'b1;
        joypad_clock  = 2'b10;
        tick();
        joypad_clock  = 2'b00;
        tick();
        joypad_strobe = 1'b0;
        tick();
        push_read(2, 8'hFF, 9);
        edges(2'b10, 9, "load_wins_ff");

        joy2_btns     = 12'h055;
        joypad_strobe = 1'b1;
        joypad_clock  = 2'b10;
        tick();
        joypad_clock  = 2'b00;
        tick();
        joypad_strobe = 1'b0;
        tick();
        push_read(2, 8'h55, 9);
        edges(2'b10, 9, "load_wins_55");

        // Buttons / turbo_en changing mid-read do not disturb the shift.
        joy1_btns = 12'h0F0;
        load();
        push_read(1, 8'hF0, 9);
        edges(2'b01, 4, "midshift_a");
        joy1_btns = 12'hFFF;
        turbo_en  = 1'b1;
        edges(2'b01, 5, "midshift_b");
        turbo_en  = 1'b0;

        // Reset mid-read aborts; shifting restarts from 8'h00.
        joy1_btns = 12'h0AD;
        load();
        push_read(1, 8'hAD, 3);
        edges(2'b01, 3, "pre_reset");
        check("pre_reset_bit3", joypad1_data, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_data1", joypad1_data, 1'b0);
        check("mid_rst_data2", joypad2_data, 1'b0);
        check("mid_rst_phase", turbo_phase, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        push_read(1, 8'h00, 9);
        edges(2'b01, 9, "post_reset");

        // Both ports clocked together with different buttons.
        joy1_btns = 12'h0A5;
        joy2_btns = 12'h03C;
        load();
        push_read(1, 8'hA5, 9);
        push_read(2, 8'h3C, 9);
        edges(2'b11, 9, "dual");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
